// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage for the single-cycle RV32I core. It owns the PC and
// fetches one instruction at a time over a req/gnt/rvalid handshake. The word
// goes to the decoder, and the next PC comes from the decoder's select and
// offset. Whenever no valid instruction is held, a NOP (ADDI x0,x0,0) is
// presented instead.
//
// Ports:
//   clk_i, rstn_i       core clock, asynchronous active-low reset
//   pc_next_sel_i       next-PC select (STALL / PC_IMM / RS1_IMM)
//   pc_next_off_i       next-PC offset
//   rs1_data_i          RS1 value used as the JALR base
//   imem_req_o          instruction memory request
//   imem_addr_o         request address, always equal to pc_o
//   imem_gnt_i          request accepted
//   imem_rvalid_i       response valid
//   imem_rdata_i        response instruction word
//   pc_o                PC of the instruction on insn_o
//   insn_o              instruction to the decoder
//   insn_valid_o        insn_o holds a fetched instruction
//   misalign_o          sticky misaligned-target flag; the core is halted
//
// state | meaning
// ------+-------------------------------------------------------------
// RESET | held in reset, or the first cycle after reset is released
// REQ   | request at pc_o is asserted until it is granted
// WAIT  | waiting for the response data
// EXEC  | instruction is valid on insn_o; the decoder selects the next PC
// HALT  | misaligned target seen; stays here until reset

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [1:0]  pc_next_sel_i,
    input  logic [31:0] pc_next_off_i,
    input  logic [31:0] rs1_data_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] insn_o,
    output logic        insn_valid_o,
    output logic        misalign_o
);

    // Encodings of the decoder's next-PC select.
    localparam logic [1:0] PC_NEXT_SEL_STALL   = 2'b00;
    localparam logic [1:0] PC_NEXT_SEL_PC_IMM  = 2'b01;
    localparam logic [1:0] PC_NEXT_SEL_RS1_IMM = 2'b10;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_RESET,
        S_REQ,
        S_WAIT,
        S_EXEC,
        S_HALT
    } state_t;

    state_t      state;
    logic [31:0] target;
    logic        advance;

    // Any select other than PC_IMM or RS1_IMM behaves as a stall.
    always_comb begin
        target  = pc_o + pc_next_off_i;
        advance = 1'b0;
        case (pc_next_sel_i)
            PC_NEXT_SEL_PC_IMM: begin
                advance = 1'b1;
            end
            PC_NEXT_SEL_RS1_IMM: begin
                target  = (rs1_data_i + pc_next_off_i) & ~32'h1;
                advance = 1'b1;
            end
            default: begin
                advance = 1'b0;
            end
        endcase
    end

    assign imem_addr_o = pc_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state        <= S_RESET;
            pc_o         <= RESET_PC;
            insn_o       <= NOP;
            insn_valid_o <= 1'b0;
            imem_req_o   <= 1'b0;
            misalign_o   <= 1'b0;
        end else begin
            case (state)
                S_RESET: begin
                    state      <= S_REQ;
                    imem_req_o <= 1'b1;
                end
                S_REQ: begin
                    if (imem_gnt_i) begin
                        state      <= S_WAIT;
                        imem_req_o <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        state        <= S_EXEC;
                        insn_o       <= imem_rdata_i;
                        insn_valid_o <= 1'b1;
                    end
                end
                S_EXEC: begin
                    if (advance) begin
                        insn_o       <= NOP;
                        insn_valid_o <= 1'b0;
                        if (target[1]) begin
                            // A misaligned target leaves the PC at the
                            // offending instruction.
                            state      <= S_HALT;
                            misalign_o <= 1'b1;
                        end else begin
                            state      <= S_REQ;
                            pc_o       <= target;
                            imem_req_o <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state        <= S_RESET;
                    insn_o       <= NOP;
                    insn_valid_o <= 1'b0;
                    imem_req_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [1:0]  ST  = 2'b00;
    localparam logic [1:0]  PCI = 2'b01;
    localparam logic [1:0]  RSI = 2'b10;
    localparam logic [1:0]  BAD = 2'b11;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic [1:0]  pc_next_sel_i = ST;
    logic [31:0] pc_next_off_i = '0;
    logic [31:0] rs1_data_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] pc_o;
    logic [31:0] insn_o;
    logic        insn_valid_o;
    logic        misalign_o;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .pc_next_sel_i (pc_next_sel_i),
        .pc_next_off_i (pc_next_off_i),
        .rs1_data_i    (rs1_data_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .insn_o        (insn_o),
        .insn_valid_o  (insn_valid_o),
        .misalign_o    (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    // One record per clock cycle: the inputs driven during that cycle and the
    // outputs expected during the same cycle, before the next rising edge.
    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic [1:0]  sel;
        logic [31:0] off;
        logic [31:0] rs1;
        logic        e_req;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_insn;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(logic g, logic rv, logic [31:0] rd, logic [1:0] s,
                                logic [31:0] o, logic [31:0] r1, logic er,
                                logic [31:0] ep, logic ev, logic [31:0] ei, logic em);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.sel = s; v.off = o; v.rs1 = r1;
        v.e_req = er; v.e_pc = ep; v.e_valid = ev; v.e_insn = ei; v.e_mis = em;
        return v;
    endfunction

    task automatic chk(string name, logic er, logic [31:0] ep, logic ev,
                       logic [31:0] ei, logic em);
        n_vec++;
        if (imem_req_o !== er || imem_addr_o !== ep || pc_o !== ep ||
            insn_valid_o !== ev || insn_o !== ei || misalign_o !== em) begin
            n_err++;
            $display("FAIL %s: got req=%b addr=%h pc=%h valid=%b insn=%h mis=%b, want req=%b addr=pc=%h valid=%b insn=%h mis=%b",
                     name, imem_req_o, imem_addr_o, pc_o, insn_valid_o, insn_o,
                     misalign_o, er, ep, ev, ei, em);
        end
    endtask

    task automatic drive(logic g, logic rv, logic [31:0] rd, logic [1:0] s,
                         logic [31:0] o, logic [31:0] r1);
        imem_gnt_i = g; imem_rvalid_i = rv; imem_rdata_i = rd;
        pc_next_sel_i = s; pc_next_off_i = o; rs1_data_i = r1;
    endtask

    initial begin
        //             gnt rv rdata          sel  off            rs1            req pc             vld insn           mis
        vecs.push_back(mk(0, 0, 32'h0,         ST,  32'h0,         32'h0,         0, 32'h0,         0, NOP,           0)); // RESET
        vecs.push_back(mk(1, 0, 32'h0,         ST,  32'h0,         32'h0,         1, 32'h0,         0, NOP,           0)); // REQ @0
        vecs.push_back(mk(0, 1, 32'h0050_0093, ST,  32'h0,         32'h0,         0, 32'h0,         0, NOP,           0)); // WAIT
        vecs.push_back(mk(0, 0, 32'h0,         PCI, 32'h4,         32'h0,         0, 32'h0,         1, 32'h0050_0093, 0)); // EXEC
        vecs.push_back(mk(0, 1, 32'hDEAD_BEEF, PCI, 32'h8,         32'h0,         1, 32'h4,         0, NOP,           0)); // REQ, gnt low 5
        vecs.push_back(mk(0, 0, 32'h0,         RSI, 32'h0,         32'h0,         1, 32'h4,         0, NOP,           0));
        vecs.push_back(mk(0, 1, 32'hDEAD_BEEF, ST,  32'h0,         32'h0,         1, 32'h4,         0, NOP,           0));
        vecs.push_back(mk(0, 0, 32'h0,         ST,  32'h0,         32'h0,         1, 32'h4,         0, NOP,           0));
        vecs.push_back(mk(0, 1, 32'hDEAD_BEEF, ST,  32'h0,         32'h0,         1, 32'h4,         0, NOP,           0));
        vecs.push_back(mk(1, 0, 32'h0,         ST,  32'h0,         32'h0,         1, 32'h4,         0, NOP,           0)); // grant
        vecs.push_back(mk(1, 0, 32'h0,         PCI, 32'h4,         32'h0,         0, 32'h4,         0, NOP,           0)); // WAIT, no data
        vecs.push_back(mk(0, 1, 32'h0000_006F, ST,  32'h0,         32'h0,         0, 32'h4,         0, NOP,           0));
        vecs.push_back(mk(0, 0, 32'h0,         ST,  32'h40,        32'h0,         0, 32'h4,         1, 32'h0000_006F, 0)); // stall 1
        vecs.push_back(mk(1, 1, 32'h1111_1111, ST,  32'h40,        32'h0,         0, 32'h4,         1, 32'h0000_006F, 0)); // stall 2
        vecs.push_back(mk(0, 0, 32'h0,         BAD, 32'h40,        32'h0,         0, 32'h4,         1, 32'h0000_006F, 0)); // stall 3
        vecs.push_back(mk(0, 0, 32'h0,         PCI, 32'hFC,        32'h0,         0, 32'h4,         1, 32'h0000_006F, 0)); // -> 0x100
        vecs.push_back(mk(1, 0, 32'h0,         ST,  32'h0,         32'h0,         1, 32'h100,       0, NOP,           0));
        vecs.push_back(mk(0, 1, 32'hF11F_F06F, ST,  32'h0,         32'h0,         0, 32'h100,       0, NOP,           0));
        vecs.push_back(mk(0, 0, 32'h0,         PCI, 32'hFFFF_FFF0, 32'h0,         0, 32'h100,       1, 32'hF11F_F06F, 0)); // -> 0xF0
        vecs.push_back(mk(1, 0, 32'h0,         ST,  32'h0,         32'h0,         1, 32'hF0,        0, NOP,           0));
        vecs.push_back(mk(0, 1, 32'h00C0_0067, ST,  32'h0,         32'h0,         0, 32'hF0,        0, NOP,           0));
        vecs.push_back(mk(0, 0, 32'h0,         RSI, 32'hC,         32'hFFFF_FFF1, 0, 32'hF0,        1, 32'h00C0_0067, 0)); // -> FFFFFFFC
        vecs.push_back(mk(1, 0, 32'h0,         ST,  32'h0,         32'h0,         1, 32'hFFFF_FFFC, 0, NOP,           0));
        vecs.push_back(mk(0, 1, 32'h0040_006F, ST,  32'h0,         32'h0,         0, 32'hFFFF_FFFC, 0, NOP,           0));
        vecs.push_back(mk(0, 0, 32'h0,         PCI, 32'h4,         32'h0,         0, 32'hFFFF_FFFC, 1, 32'h0040_006F, 0)); // wrap -> 0
        vecs.push_back(mk(1, 0, 32'h0,         ST,  32'h0,         32'h0,         1, 32'h0,         0, NOP,           0));
        vecs.push_back(mk(0, 1, 32'h0000_8067, ST,  32'h0,         32'h0,         0, 32'h0,         0, NOP,           0));
        vecs.push_back(mk(0, 0, 32'h0,         RSI, 32'h0,         32'h201,       0, 32'h0,         1, 32'h0000_8067, 0)); // -> 0x200
        vecs.push_back(mk(1, 0, 32'h0,         ST,  32'h0,         32'h0,         1, 32'h200,       0, NOP,           0));
        vecs.push_back(mk(0, 1, 32'h0000_8067, ST,  32'h0,         32'h0,         0, 32'h200,       0, NOP,           0));
        vecs.push_back(mk(0, 0, 32'h0,         RSI, 32'h0,         32'h203,       0, 32'h200,       1, 32'h0000_8067, 0)); // 0x202 misaligned
        vecs.push_back(mk(1, 1, 32'h2222_2222, PCI, 32'h4,         32'h0,         0, 32'h200,       0, NOP,           1)); // HALT
        vecs.push_back(mk(1, 1, 32'h2222_2222, RSI, 32'h4,         32'h0,         0, 32'h200,       0, NOP,           1));
        vecs.push_back(mk(0, 0, 32'h0,         PCI, 32'h4,         32'h0,         0, 32'h200,       0, NOP,           1));

        #12 chk("reset_asserted", 0, 32'h0, 0, NOP, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].sel,
                  vecs[i].off, vecs[i].rs1);
            #1 chk($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc,
                   vecs[i].e_valid, vecs[i].e_insn, vecs[i].e_mis);
            @(negedge clk_i);
        end

        // Reset while halted clears the sticky flag immediately.
        drive(0, 0, 32'h0, ST, 32'h0, 32'h0);
        #2 rstn_i = 1'b0;
        #1 chk("halt_reset", 0, 32'h0, 0, NOP, 0);
        @(negedge clk_i);
        rstn_i = 1'b1;
        #1 chk("post_rst_reset_state", 0, 32'h0, 0, NOP, 0);
        @(negedge clk_i);
        drive(1, 0, 32'h0, ST, 32'h0, 32'h0);
        #1 chk("post_rst_req0", 1, 32'h0, 0, NOP, 0);
        @(negedge clk_i);
        drive(0, 1, 32'hABCD_0013, ST, 32'h0, 32'h0);
        @(negedge clk_i);
        drive(0, 0, 32'h0, PCI, 32'h40, 32'h0);
        #1 chk("exec_before_jump", 0, 32'h0, 1, 32'hABCD_0013, 0);
        @(negedge clk_i);
        drive(1, 0, 32'h0, ST, 32'h0, 32'h0);
        #1 chk("req_at_40", 1, 32'h40, 0, NOP, 0);
        @(negedge clk_i);
        drive(0, 0, 32'h0, ST, 32'h0, 32'h0);
        #1 chk("wait_at_40", 0, 32'h40, 0, NOP, 0);

        // Reset in the middle of WAIT abandons the fetch at once.
        #2 rstn_i = 1'b0;
        #1 chk("mid_wait_reset", 0, 32'h0, 0, NOP, 0);
        drive(0, 1, 32'h5555_5555, PCI, 32'h4, 32'h0);
        @(negedge clk_i);
        #1 chk("held_in_reset", 0, 32'h0, 0, NOP, 0);
        drive(0, 0, 32'h0, ST, 32'h0, 32'h0);
        rstn_i = 1'b1;
        @(negedge clk_i);
        #1 chk("fresh_req_after_reset", 1, 32'h0, 0, NOP, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle RV32I core, directly upstream of the instruction decoder/control block. It owns the program counter and fetches one instruction at a time from instruction memory over a request/grant/response handshake. It presents the instruction word to the decoder, then computes the next PC from the decoder's next-PC select/offset and the RS1 register value. While no valid instruction is held, it presents a NOP so the decoder produces no architectural effect.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- clk_i  input  1  core clock; all state updates on rising edge.
- rstn_i  input  1  reset, asynchronous and active-low.
- pc_next_sel_i  input  2  next-PC select from decoder; uses the `PC_NEXT_SEL_STALL`, `PC_NEXT_SEL_PC_IMM` and `PC_NEXT_SEL_RS1_IMM` macros from const.v.
- pc_next_off_i  input  32  next-PC offset from decoder.
- rs1_data_i  input  32  RS1 read data from register file (JALR base).
- imem_req_o  output  1  instruction memory request.
- imem_addr_o  output  32  request address.
- imem_gnt_i  input  1  request accepted this cycle.
- imem_rvalid_i  input  1  response data valid.
- imem_rdata_i  input  32  response instruction word.
- pc_o  output  32  PC of the instruction on insn_o.
- insn_o  output  32  instruction to decoder (pc_data_i).
- insn_valid_o  output  1  insn_o holds a fetched instruction.
- misalign_o  output  1  sticky: branch target not 4-byte aligned; core halted.

## Operation
- States: RESET, REQ, WAIT, EXEC, HALT.
- RESET: entered asynchronously on rstn_i low. Leaves to REQ on the first clock edge with rstn_i high.
- REQ:
  - imem_req_o=1 and imem_addr_o=pc_o, held stable until imem_gnt_i.
  - gnt -> WAIT.
- WAIT:
  - imem_req_o=0.
  - On imem_rvalid_i: capture imem_rdata_i into the instruction register and go to EXEC.
- EXEC:
  - insn_valid_o=1 and insn_o=captured word.
  - pc_next_sel_i is sampled at the clock edge that ends the cycle:
    - STALL: stay in EXEC, instruction and PC held.
    - PC_IMM: target = pc_o + pc_next_off_i.
    - RS1_IMM: target = (rs1_data_i + pc_next_off_i) & ~32'h1.
  - Any other encoding is treated as STALL.
  - Target with bit 1 set: set misalign_o, PC unchanged, go to HALT.
  - Otherwise: pc_o <= target, go to REQ.
- HALT: absorbing until reset. insn_valid_o=0, imem_req_o=0.
- Whenever insn_valid_o=0, insn_o=32'h0000_0013 (ADDI x0,x0,0). pc_next_sel_i is ignored outside EXEC.
- Arithmetic is 32-bit modulo 2^32; wrap-around (e.g. 32'hFFFF_FFFC + 4 = 0) is legal.
- Only one outstanding memory request at a time.
  - imem_rvalid_i outside WAIT is ignored.
  - imem_gnt_i outside REQ is ignored.
- Instruction memory shares rstn_i. No response for a request issued before reset is delivered after reset.

## Timing
- Reset values:
  - pc_o=RESET_PC, imem_addr_o=RESET_PC.
  - insn_o=32'h0000_0013, insn_valid_o=0, imem_req_o=0, misalign_o=0.
  - State RESET.
- imem_addr_o is combinationally equal to pc_o.
- imem_rvalid_i is permitted no earlier than the cycle after the imem_gnt_i cycle.
- Minimum cadence is 3 cycles per instruction (REQ with immediate gnt, WAIT with rvalid, EXEC).
- insn_o/insn_valid_o are registered. They change only on entering or leaving EXEC.
- pc_o updates on the edge that leaves EXEC. The new request is visible the same cycle state becomes REQ.
- Reset asserted mid-REQ/WAIT/EXEC: all outputs return to reset values immediately (asynchronously). The in-flight fetch is abandoned.

## Test plan
- Reset, then gnt and rvalid each one cycle after request:
  - First request at addr RESET_PC=0.
  - rdata 32'h0050_0093 appears on insn_o with insn_valid_o=1 for one cycle.
  - PC_IMM with off 4 -> next request at addr 4.
  - insn_o reverts to 32'h0000_0013 between instructions.
- Hold imem_gnt_i low 5 cycles in REQ -> imem_req_o stays 1 and addr stays stable. Spurious rvalid during REQ is ignored.
- JAL: pc_o=32'h100, PC_IMM, off 32'hFFFF_FFF0 -> next addr 32'hF0.
  - Wrap check: pc_o=32'hFFFF_FFFC, off 4 -> addr 0.
- JALR: RS1_IMM, rs1=32'h203, off 0 -> next addr 32'h202 & bit1 set -> misalign_o=1, HALT, no further requests.
  - Repeat with rs1=32'h201 -> next addr 32'h200, normal fetch.
- EXEC with STALL for 3 cycles -> insn_valid_o=1 and insn_o/pc_o unchanged throughout, then PC_IMM advances.
- Assert rstn_i low mid-WAIT -> outputs return to reset values immediately. After release, a fresh request at RESET_PC.
